// File: rtl/decode_unit_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes, the canonical NOP
// and the layout of the decode->execute pipeline register.
package decode_unit_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 5;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_PASSB  = 5'd10;
  localparam logic [4:0] ALU_M_BASE = 5'd16;

  // All-zero value of this struct is the bubble (ALU_ADD is code 0).
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] rs1_val;
    logic [WORD_W-1:0] rs2_val;
    logic [WORD_W-1:0] imm;
    logic [IDX_W-1:0]  rd;
    logic [IDX_W-1:0]  rs1_idx;
    logic [IDX_W-1:0]  rs2_idx;
    logic [4:0]        alu_op;
    logic [2:0]        funct3;
    logic              alu_src_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              is_branch;
    logic              is_jal;
    logic              is_jalr;
    logic              is_lui;
    logic              is_auipc;
    logic              illegal;
  } ex_reg_t;

endpackage

// File: rtl/decode_unit_if.sv
// Decode-stage bus: fetch register in, register-file read port, stall back to fetch,
// and the decode->execute operand/control bundle out.
interface decode_unit_if;
  import decode_unit_pkg::*;

  logic [WORD_W-1:0] inst_from_fetch;
  logic [WORD_W-1:0] inst_addr_from_fetch;
  logic              branch_signal_from_execute_stage;
  logic [IDX_W-1:0]  rs1_addr;
  logic [IDX_W-1:0]  rs2_addr;
  logic [WORD_W-1:0] rs1_data;
  logic [WORD_W-1:0] rs2_data;
  logic              stall_pipeline_signal_to_fetch_stage;
  logic [WORD_W-1:0] ex_pc;
  logic [WORD_W-1:0] ex_rs1_val;
  logic [WORD_W-1:0] ex_rs2_val;
  logic [WORD_W-1:0] ex_imm;
  logic [IDX_W-1:0]  ex_rd;
  logic [IDX_W-1:0]  ex_rs1_idx;
  logic [IDX_W-1:0]  ex_rs2_idx;
  logic [4:0]        ex_alu_op;
  logic [2:0]        ex_funct3;
  logic              ex_alu_src_imm;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_is_branch;
  logic              ex_is_jal;
  logic              ex_is_jalr;
  logic              ex_is_lui;
  logic              ex_is_auipc;
  logic              ex_illegal;

  modport master (
    input  inst_from_fetch, inst_addr_from_fetch, branch_signal_from_execute_stage,
    input  rs1_data, rs2_data,
    output rs1_addr, rs2_addr, stall_pipeline_signal_to_fetch_stage,
    output ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rs1_idx, ex_rs2_idx,
    output ex_alu_op, ex_funct3, ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write,
    output ex_is_branch, ex_is_jal, ex_is_jalr, ex_is_lui, ex_is_auipc, ex_illegal
  );

  modport slave (
    output inst_from_fetch, inst_addr_from_fetch, branch_signal_from_execute_stage,
    output rs1_data, rs2_data,
    input  rs1_addr, rs2_addr, stall_pipeline_signal_to_fetch_stage,
    input  ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rs1_idx, ex_rs2_idx,
    input  ex_alu_op, ex_funct3, ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write,
    input  ex_is_branch, ex_is_jal, ex_is_jalr, ex_is_lui, ex_is_auipc, ex_illegal
  );

endinterface

// File: rtl/decode_unit_imm_gen.sv
// RV32I immediate generator: instruction word -> sign-extended 32-bit immediate.
// Purely combinational so fetch-side branch prediction can reuse it.
module decode_unit_imm_gen
  import decode_unit_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (inst_i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      OPC_STORE:
        imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      OPC_BRANCH:
        imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_o = {inst_i[31:12], 12'b0};
      OPC_JAL:
        imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage with load-use stall and decode->execute pipeline register.
// Define RV32M_DECODE_EN to decode the M-extension (MUL/DIV/REM) encodings.
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  decode_unit_if.master bus
);

  logic [XLEN-1:0]       inst;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0]       imm;
  logic                  uses_rs1, uses_rs2, no_rd, is_nop;
  logic                  hazard, flush;
  ex_reg_t               ex_d, ex_q;

  assign inst   = bus.inst_from_fetch;
  assign opcode = inst[6:0];
  assign rd_f   = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1_f  = inst[19:15];
  assign rs2_f  = inst[24:20];
  assign funct7 = inst[31:25];
  assign flush  = bus.branch_signal_from_execute_stage;

  assign bus.rs1_addr = rs1_f;
  assign bus.rs2_addr = rs2_f;

  decode_unit_imm_gen u_imm_gen (
    .inst_i (inst),
    .imm_o  (imm)
  );

  always_comb begin
    ex_d     = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    no_rd    = 1'b0;
    is_nop   = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        ex_d.reg_write = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  ex_d.alu_op = ALU_ADD;
              3'b001:  ex_d.alu_op = ALU_SLL;
              3'b010:  ex_d.alu_op = ALU_SLT;
              3'b011:  ex_d.alu_op = ALU_SLTU;
              3'b100:  ex_d.alu_op = ALU_XOR;
              3'b101:  ex_d.alu_op = ALU_SRL;
              3'b110:  ex_d.alu_op = ALU_OR;
              default: ex_d.alu_op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      ex_d.alu_op = ALU_SUB;
            else if (funct3 == 3'b101) ex_d.alu_op = ALU_SRA;
            else                       ex_d.illegal = 1'b1;
          end
          7'b0000001: begin
`ifdef RV32M_DECODE_EN
            ex_d.alu_op = ALU_M_BASE | {2'b00, funct3};
`else
            ex_d.illegal = 1'b1;
`endif
          end
          default: ex_d.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1;
        ex_d.alu_src_imm = 1'b1;
        ex_d.reg_write   = 1'b1;
        case (funct3)
          3'b000: ex_d.alu_op = ALU_ADD;
          3'b010: ex_d.alu_op = ALU_SLT;
          3'b011: ex_d.alu_op = ALU_SLTU;
          3'b100: ex_d.alu_op = ALU_XOR;
          3'b110: ex_d.alu_op = ALU_OR;
          3'b111: ex_d.alu_op = ALU_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) ex_d.alu_op = ALU_SLL;
            else                      ex_d.illegal = 1'b1;
          end
          default: begin
            if (funct7 == 7'b0000000)      ex_d.alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) ex_d.alu_op = ALU_SRA;
            else                           ex_d.illegal = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        uses_rs1 = 1'b1;
        ex_d.alu_src_imm = 1'b1;
        ex_d.reg_write   = 1'b1;
        ex_d.mem_read    = 1'b1;
        if (funct3 == 3'b011 || funct3[2:1] == 2'b11) ex_d.illegal = 1'b1;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        no_rd    = 1'b1;
        ex_d.alu_src_imm = 1'b1;
        ex_d.mem_write   = 1'b1;
        if (funct3[2] || funct3 == 3'b011) ex_d.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        no_rd    = 1'b1;
        ex_d.alu_op    = ALU_SUB;
        ex_d.is_branch = 1'b1;
        if (funct3[2:1] == 2'b01) ex_d.illegal = 1'b1;
      end
      OPC_JAL: begin
        ex_d.is_jal    = 1'b1;
        ex_d.reg_write = 1'b1;
      end
      OPC_JALR: begin
        uses_rs1 = 1'b1;
        ex_d.alu_src_imm = 1'b1;
        ex_d.is_jalr     = 1'b1;
        ex_d.reg_write   = 1'b1;
        if (funct3 != 3'b000) ex_d.illegal = 1'b1;
      end
      OPC_LUI: begin
        ex_d.alu_op      = ALU_PASSB;
        ex_d.alu_src_imm = 1'b1;
        ex_d.is_lui      = 1'b1;
        ex_d.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        ex_d.alu_src_imm = 1'b1;
        ex_d.is_auipc    = 1'b1;
        ex_d.reg_write   = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        no_rd  = 1'b1;
        is_nop = 1'b1;
      end
      default: ex_d.illegal = 1'b1;
    endcase

    // An illegal word must not write state, redirect, or raise a spurious stall.
    if (ex_d.illegal) begin
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
      ex_d.is_branch = 1'b0;
      ex_d.is_jal    = 1'b0;
      ex_d.is_jalr   = 1'b0;
      uses_rs1       = 1'b0;
      uses_rs2       = 1'b0;
    end

    ex_d.rd      = no_rd ? '0 : rd_f;
    ex_d.rs1_idx = uses_rs1 ? rs1_f : '0;
    ex_d.rs2_idx = uses_rs2 ? rs2_f : '0;
    ex_d.funct3  = is_nop ? 3'b000 : funct3;
    ex_d.imm     = is_nop ? '0 : imm;
    ex_d.pc      = bus.inst_addr_from_fetch;
    ex_d.rs1_val = bus.rs1_data;
    ex_d.rs2_val = bus.rs2_data;
  end

  assign hazard = ex_q.mem_read & (ex_q.rd != '0) &
                  ((uses_rs1 & (ex_q.rd == rs1_f)) | (uses_rs2 & (ex_q.rd == rs2_f)));

  assign bus.stall_pipeline_signal_to_fetch_stage = hazard & ~flush & ~rst;

  // Decode -> execute boundary: flush and load-use both insert a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || hazard) ex_q <= '0;
    else                        ex_q <= ex_d;
  end

  assign bus.ex_pc          = ex_q.pc;
  assign bus.ex_rs1_val     = ex_q.rs1_val;
  assign bus.ex_rs2_val     = ex_q.rs2_val;
  assign bus.ex_imm         = ex_q.imm;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_rs1_idx     = ex_q.rs1_idx;
  assign bus.ex_rs2_idx     = ex_q.rs2_idx;
  assign bus.ex_alu_op      = ex_q.alu_op;
  assign bus.ex_funct3      = ex_q.funct3;
  assign bus.ex_alu_src_imm = ex_q.alu_src_imm;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_is_branch   = ex_q.is_branch;
  assign bus.ex_is_jal      = ex_q.is_jal;
  assign bus.ex_is_jalr     = ex_q.is_jalr;
  assign bus.ex_is_lui      = ex_q.is_lui;
  assign bus.ex_is_auipc    = ex_q.is_auipc;
  assign bus.ex_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// Directed-vector bench for decode_unit: reset, decode formats, load-use stall,
// flush, illegal words and the optional M-extension decode.
module tb_decode_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  decode_unit_if bus ();

  decode_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: value encodes the index read.
  always_comb begin
    bus.rs1_data = 32'hA000_0000 | {27'b0, bus.rs1_addr};
    bus.rs2_data = 32'hB000_0000 | {27'b0, bus.rs2_addr};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [160:0] all_ex;
    rst = 1'b1;
    bus.inst_from_fetch = 32'h0050_0093;
    bus.inst_addr_from_fetch = 32'h0000_0040;
    bus.branch_signal_from_execute_stage = 1'b0;
    step();
    step();
    all_ex = {bus.ex_pc, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm, bus.ex_rd,
              bus.ex_rs1_idx, bus.ex_rs2_idx, bus.ex_alu_op, bus.ex_funct3,
              bus.ex_alu_src_imm, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
              bus.ex_is_branch, bus.ex_is_jal, bus.ex_is_jalr, bus.ex_is_lui,
              bus.ex_is_auipc, bus.ex_illegal};
    total++; if (all_ex !== '0) begin bad++; $display("FAIL reset_ex got=%h exp=0", all_ex); end
    total++; if (bus.stall_pipeline_signal_to_fetch_stage !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall_pipeline_signal_to_fetch_stage); end
    rst = 1'b0;
    step();
    total++; if (bus.ex_rd !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d exp=1", bus.ex_rd); end
    total++; if (bus.ex_imm !== 32'd5) begin bad++; $display("FAIL addi_imm got=%h exp=5", bus.ex_imm); end
    total++; if (bus.ex_alu_op !== 5'd0) begin bad++; $display("FAIL addi_aluop got=%0d exp=0", bus.ex_alu_op); end
    total++; if (bus.ex_alu_src_imm !== 1'b1) begin bad++; $display("FAIL addi_srcimm got=%b exp=1", bus.ex_alu_src_imm); end
    total++; if (bus.ex_reg_write !== 1'b1) begin bad++; $display("FAIL addi_regwrite got=%b exp=1", bus.ex_reg_write); end
    total++; if (bus.ex_pc !== 32'h40) begin bad++; $display("FAIL addi_pc got=%h exp=40", bus.ex_pc); end
  endtask

  task automatic test_load_use();
    bus.inst_from_fetch = 32'h0000_A103;
    bus.inst_addr_from_fetch = 32'h0000_0100;
    step();
    total++; if (bus.ex_mem_read !== 1'b1) begin bad++; $display("FAIL lw_memread got=%b exp=1", bus.ex_mem_read); end
    bus.inst_from_fetch = 32'h0011_01B3;
    bus.inst_addr_from_fetch = 32'h0000_0104;
    #1;
    total++; if (bus.stall_pipeline_signal_to_fetch_stage !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", bus.stall_pipeline_signal_to_fetch_stage); end
    step();
    total++; if (bus.ex_reg_write !== 1'b0) begin bad++; $display("FAIL lu_bubble_rw got=%b exp=0", bus.ex_reg_write); end
    total++; if (bus.ex_rd !== 5'd0) begin bad++; $display("FAIL lu_bubble_rd got=%0d exp=0", bus.ex_rd); end
    total++; if (bus.stall_pipeline_signal_to_fetch_stage !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%b exp=0", bus.stall_pipeline_signal_to_fetch_stage); end
    step();
    total++; if (bus.ex_rd !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d exp=3", bus.ex_rd); end
    total++; if (bus.ex_rs1_idx !== 5'd2) begin bad++; $display("FAIL add_rs1idx got=%0d exp=2", bus.ex_rs1_idx); end
    total++; if (bus.ex_rs2_idx !== 5'd1) begin bad++; $display("FAIL add_rs2idx got=%0d exp=1", bus.ex_rs2_idx); end
    total++; if (bus.ex_rs1_val !== 32'hA000_0002) begin bad++; $display("FAIL add_rs1val got=%h exp=a0000002", bus.ex_rs1_val); end
    total++; if (bus.ex_rs2_val !== 32'hB000_0001) begin bad++; $display("FAIL add_rs2val got=%h exp=b0000001", bus.ex_rs2_val); end
    total++; if (bus.ex_pc !== 32'h104) begin bad++; $display("FAIL add_pc got=%h exp=104", bus.ex_pc); end
  endtask

  task automatic test_flush();
    bus.inst_from_fetch = 32'h0000_A103;
    step();
    bus.inst_from_fetch = 32'h0011_01B3;
    bus.branch_signal_from_execute_stage = 1'b1;
    #1;
    total++; if (bus.stall_pipeline_signal_to_fetch_stage !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", bus.stall_pipeline_signal_to_fetch_stage); end
    step();
    bus.branch_signal_from_execute_stage = 1'b0;
    total++; if (bus.ex_reg_write !== 1'b0) begin bad++; $display("FAIL flush_rw got=%b exp=0", bus.ex_reg_write); end
    total++; if (bus.ex_rd !== 5'd0) begin bad++; $display("FAIL flush_rd got=%0d exp=0", bus.ex_rd); end
    total++; if (bus.ex_mem_read !== 1'b0) begin bad++; $display("FAIL flush_memread got=%b exp=0", bus.ex_mem_read); end
    total++; if (bus.ex_pc !== 32'h0) begin bad++; $display("FAIL flush_pc got=%h exp=0", bus.ex_pc); end
  endtask

  task automatic test_store();
    bus.inst_from_fetch = 32'hFE20_AE23;
    bus.inst_addr_from_fetch = 32'h0000_0200;
    #1;
    total++; if (bus.rs1_addr !== 5'd1) begin bad++; $display("FAIL sw_rs1addr got=%0d exp=1", bus.rs1_addr); end
    total++; if (bus.rs2_addr !== 5'd2) begin bad++; $display("FAIL sw_rs2addr got=%0d exp=2", bus.rs2_addr); end
    step();
    total++; if (bus.ex_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL sw_imm got=%h exp=fffffffc", bus.ex_imm); end
    total++; if (bus.ex_mem_write !== 1'b1) begin bad++; $display("FAIL sw_memwrite got=%b exp=1", bus.ex_mem_write); end
    total++; if (bus.ex_rd !== 5'd0) begin bad++; $display("FAIL sw_rd got=%0d exp=0", bus.ex_rd); end
    total++; if (bus.ex_funct3 !== 3'b010) begin bad++; $display("FAIL sw_funct3 got=%b exp=010", bus.ex_funct3); end
    total++; if (bus.ex_reg_write !== 1'b0) begin bad++; $display("FAIL sw_rw got=%b exp=0", bus.ex_reg_write); end
    total++; if (bus.ex_rs2_val !== 32'hB000_0002) begin bad++; $display("FAIL sw_rs2val got=%h exp=b0000002", bus.ex_rs2_val); end
  endtask

  task automatic test_m_ext();
    bus.inst_from_fetch = 32'h0220_81B3;
    step();
`ifdef RV32M_DECODE_EN
    total++; if (bus.ex_alu_op !== 5'd16) begin bad++; $display("FAIL mul_aluop got=%0d exp=16", bus.ex_alu_op); end
    total++; if (bus.ex_illegal !== 1'b0) begin bad++; $display("FAIL mul_illegal got=%b exp=0", bus.ex_illegal); end
    total++; if (bus.ex_reg_write !== 1'b1) begin bad++; $display("FAIL mul_rw got=%b exp=1", bus.ex_reg_write); end
`else
    total++; if (bus.ex_illegal !== 1'b1) begin bad++; $display("FAIL mul_illegal got=%b exp=1", bus.ex_illegal); end
    total++; if (bus.ex_reg_write !== 1'b0) begin bad++; $display("FAIL mul_rw got=%b exp=0", bus.ex_reg_write); end
`endif
  endtask

  task automatic test_illegal();
    bus.inst_from_fetch = 32'h0000_0000;
    step();
    total++; if (bus.ex_illegal !== 1'b1) begin bad++; $display("FAIL zero_illegal got=%b exp=1", bus.ex_illegal); end
    total++; if ({bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write} !== 3'b000) begin bad++; $display("FAIL zero_ctrl got=%b exp=000", {bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write}); end
    // OP with funct7 0100000 and funct3 001 is not a valid encoding
    bus.inst_from_fetch = 32'h4011_11B3;
    step();
    total++; if (bus.ex_illegal !== 1'b1) begin bad++; $display("FAIL badf7_illegal got=%b exp=1", bus.ex_illegal); end
    bus.inst_from_fetch = 32'h0000_0073;
    step();
    total++; if (bus.ex_illegal !== 1'b0) begin bad++; $display("FAIL ecall_illegal got=%b exp=0", bus.ex_illegal); end
    total++; if (bus.ex_reg_write !== 1'b0) begin bad++; $display("FAIL ecall_rw got=%b exp=0", bus.ex_reg_write); end
  endtask

  task automatic test_formats();
    bus.inst_from_fetch = 32'h1234_52B7;
    step();
    total++; if (bus.ex_imm !== 32'h1234_5000) begin bad++; $display("FAIL lui_imm got=%h exp=12345000", bus.ex_imm); end
    total++; if (bus.ex_alu_op !== 5'd10) begin bad++; $display("FAIL lui_aluop got=%0d exp=10", bus.ex_alu_op); end
    total++; if ({bus.ex_is_lui, bus.ex_rd} !== {1'b1, 5'd5}) begin bad++; $display("FAIL lui_ctrl got=%b/%0d exp=1/5", bus.ex_is_lui, bus.ex_rd); end
    bus.inst_from_fetch = 32'hFE20_8CE3;
    step();
    total++; if (bus.ex_imm !== 32'hFFFF_FFF8) begin bad++; $display("FAIL beq_imm got=%h exp=fffffff8", bus.ex_imm); end
    total++; if ({bus.ex_is_branch, bus.ex_rd} !== {1'b1, 5'd0}) begin bad++; $display("FAIL beq_ctrl got=%b/%0d exp=1/0", bus.ex_is_branch, bus.ex_rd); end
    bus.inst_from_fetch = 32'h0100_00EF;
    step();
    total++; if (bus.ex_imm !== 32'd16) begin bad++; $display("FAIL jal_imm got=%h exp=10", bus.ex_imm); end
    total++; if ({bus.ex_is_jal, bus.ex_reg_write, bus.ex_rd} !== {2'b11, 5'd1}) begin bad++; $display("FAIL jal_ctrl got=%b%b/%0d exp=11/1", bus.ex_is_jal, bus.ex_reg_write, bus.ex_rd); end
    bus.inst_from_fetch = 32'h4030_D093;
    step();
    total++; if (bus.ex_alu_op !== 5'd7) begin bad++; $display("FAIL srai_aluop got=%0d exp=7", bus.ex_alu_op); end
    total++; if (bus.ex_rs2_idx !== 5'd0) begin bad++; $display("FAIL srai_rs2idx got=%0d exp=0", bus.ex_rs2_idx); end
  endtask

  task automatic test_hazard_boundary();
    bus.inst_from_fetch = 32'h0000_A003;
    step();
    bus.inst_from_fetch = 32'h0010_01B3;
    #1;
    total++; if (bus.stall_pipeline_signal_to_fetch_stage !== 1'b0) begin bad++; $display("FAIL x0_load_stall got=%b exp=0", bus.stall_pipeline_signal_to_fetch_stage); end
    step();
    bus.inst_from_fetch = 32'h0000_A103;
    step();
    bus.inst_from_fetch = 32'h0020_8193;
    #1;
    total++; if (bus.stall_pipeline_signal_to_fetch_stage !== 1'b0) begin bad++; $display("FAIL itype_rs2_stall got=%b exp=0", bus.stall_pipeline_signal_to_fetch_stage); end
    bus.inst_from_fetch = 32'hFE20_AE23;
    #1;
    total++; if (bus.stall_pipeline_signal_to_fetch_stage !== 1'b1) begin bad++; $display("FAIL store_rs2_stall got=%b exp=1", bus.stall_pipeline_signal_to_fetch_stage); end
    step();
    step();
    total++; if (bus.ex_mem_write !== 1'b1) begin bad++; $display("FAIL store_after_stall got=%b exp=1", bus.ex_mem_write); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.inst_from_fetch = 32'h0;
    bus.inst_addr_from_fetch = 32'h0;
    bus.branch_signal_from_execute_stage = 1'b0;
    test_reset();
    test_load_use();
    test_flush();
    test_store();
    test_m_ext();
    test_illegal();
    test_formats();
    test_hazard_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
